// File: rtl/bit_serial_alu_seq_if.sv
// bit_serial_alu_seq_if: request/result bundle (start,a,b,alu_ctl in; busy,done,result,zero,overflow,carry_out out)
interface bit_serial_alu_seq_if #(parameter int WIDTH = 8) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       alu_ctl;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;
  modport master (output start, a, b, alu_ctl, input busy, done, result, zero, overflow, carry_out);
  modport slave  (input start, a, b, alu_ctl, output busy, done, result, zero, overflow, carry_out);
endinterface

// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: drives a 1-bit ALU slice LSB-first over WIDTH cycles (ports: clk, rst, bus slave)
module bit_serial_alu_seq #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  bit_serial_alu_seq_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cin_msb_q, cin_msb_d, sum_msb_q, sum_msb_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [3:0]       ctl_q, ctl_d;
  logic             zero_q, zero_d, ovf_q, ovf_d, co_q, co_d, done_q, done_d;
  logic             ai, bi, sum, cout, slice, last, valid, arith;
  logic [WIDTH-1:0] fin_res;
  always_comb begin
    ai      = a_q[cnt_q] ^ ctl_q[3];
    bi      = b_q[cnt_q] ^ ctl_q[2];
    sum     = ai ^ bi ^ carry_q;
    cout    = (ai & bi) | (ai & carry_q) | (bi & carry_q);
    slice   = ctl_q[1:0] == 2'd0 ? ai & bi : ctl_q[1:0] == 2'd1 ? ai | bi : ctl_q[1:0] == 2'd2 ? sum : 1'b0;
    last    = cnt_q == CW'(WIDTH - 1);
    valid   = ctl_q inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100};
    arith   = ctl_q inside {4'b0010, 4'b0110, 4'b0111};
    fin_res = !valid ? '0 : ctl_q == 4'b0111 ? {{(WIDTH-1){1'b0}}, sum_msb_q ^ cin_msb_q ^ carry_q} : res_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cin_msb_d = cin_msb_q;
    sum_msb_d = sum_msb_q;
    a_d       = a_q;
    b_d       = b_q;
    ctl_d     = ctl_q;
    res_d     = res_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    co_d      = co_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.a;
        b_d     = bus.b;
        ctl_d   = bus.alu_ctl;
        carry_d = bus.alu_ctl[2];
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        res_d[cnt_q] = slice;
        carry_d      = cout;
        if (last) begin
          cin_msb_d = carry_q;
          sum_msb_d = sum;
          state_d   = FINISH;
        end else cnt_d = cnt_q + 1'b1;
      end
      FINISH: begin
        res_d   = fin_res;
        zero_d  = fin_res == '0;
        ovf_d   = arith & (cin_msb_q ^ carry_q);
        co_d    = arith & carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      cin_msb_q <= 1'b0;
      sum_msb_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      ctl_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      co_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      cin_msb_q <= cin_msb_d;
      sum_msb_q <= sum_msb_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ctl_q     <= ctl_d;
      res_q     <= res_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      co_q      <= co_d;
      done_q    <= done_d;
    end
  end
  assign bus.busy      = state_q != IDLE;
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = co_q;
endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// tb_bit_serial_alu_seq: directed-vector self-checking bench for bit_serial_alu_seq
module tb_bit_serial_alu_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  typedef struct {logic [3:0] c; logic [7:0] a, b, r; logic z, v, co;} vec_t;
  bit_serial_alu_seq_if #(.WIDTH(8)) bus ();
  bit_serial_alu_seq #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic do_op(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, output int n);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.alu_ctl = c; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~a; bus.b = ~b;
    n = 0;
    while (bus.done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask
  task automatic check_vecs(input string name, input vec_t v [5], input int cnt);
    int n;
    for (int i = 0; i < cnt; i++) begin
      do_op(v[i].c, v[i].a, v[i].b, n);
      n_cmp++; if (n !== 9) begin n_bad++; $display("FAIL %s[%0d] latency: got %0d edges, expected 9", name, i, n); end
      n_cmp++; if (bus.result !== v[i].r) begin n_bad++; $display("FAIL %s[%0d] result: got %h, expected %h", name, i, bus.result, v[i].r); end
      n_cmp++; if (bus.zero !== v[i].z) begin n_bad++; $display("FAIL %s[%0d] zero: got %b, expected %b", name, i, bus.zero, v[i].z); end
      n_cmp++; if (bus.overflow !== v[i].v) begin n_bad++; $display("FAIL %s[%0d] overflow: got %b, expected %b", name, i, bus.overflow, v[i].v); end
      n_cmp++; if (bus.carry_out !== v[i].co) begin n_bad++; $display("FAIL %s[%0d] carry_out: got %b, expected %b", name, i, bus.carry_out, v[i].co); end
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.carry_out} !== 13'd0) begin
      n_bad++; $display("FAIL reset outputs: got %b, expected 0", {bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.carry_out});
    end
    rst = 1'b0;
  endtask
  task automatic test_arith();
    vec_t v [5];
    v[0] = '{4'b0010, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
    v[1] = '{4'b0110, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
    v[2] = '{4'b0111, 8'hFD, 8'h02, 8'h01, 1'b0, 1'b0, 1'b1};
    v[3] = '{4'b0111, 8'h80, 8'h7F, 8'h01, 1'b0, 1'b1, 1'b1};
    v[4] = '{4'b0111, 8'h02, 8'hFD, 8'h00, 1'b1, 1'b0, 1'b0};
    check_vecs("arith", v, 5);
  endtask
  task automatic test_logic();
    vec_t v [5];
    v[0] = '{4'b1100, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0, 1'b0};
    v[1] = '{4'b0001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0, 1'b0};
    v[2] = '{4'b0000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0};
    v[3] = '{4'b0101, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0};
    v[4] = '{4'b1110, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    check_vecs("logic", v, 5);
  endtask
  task automatic test_reset_mid();
    bit saw_done = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.alu_ctl = 4'b0010; bus.a = 8'h07; bus.b = 8'h00;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.carry_out} !== 13'd0) begin
      n_bad++; $display("FAIL mid_reset outputs: got %b, expected 0", {bus.busy, bus.done, bus.result, bus.zero, bus.overflow, bus.carry_out});
    end
    rst = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (bus.done === 1'b1) saw_done = 1'b1; end
    n_cmp++; if (saw_done !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset no_done: done seen %b busy %b, expected 0 0", saw_done, bus.busy);
    end
  endtask
  task automatic test_back_to_back();
    int k;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.alu_ctl = 4'b0010; bus.a = 8'h01; bus.b = 8'h02;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b busy: got %b, expected 1", bus.busy); end
    @(posedge clk); #1;
    bus.start = 1'b1; bus.alu_ctl = 4'b0001; bus.a = 8'hF0; bus.b = 8'h0F;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 2;
    while (bus.done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++; if (k !== 9) begin n_bad++; $display("FAIL b2b first_latency: got %0d, expected 9", k); end
    n_cmp++; if (bus.result !== 8'h03) begin n_bad++; $display("FAIL b2b first_result: got %h, expected 03", bus.result); end
    bus.start = 1'b1; bus.alu_ctl = 4'b0110; bus.a = 8'h09; bus.b = 8'h04;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL b2b accept: done %b busy %b, expected 0 1", bus.done, bus.busy);
    end
    k = 1;
    while (bus.done !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    n_cmp++; if (k !== 10) begin n_bad++; $display("FAIL b2b second_gap: got %0d, expected 10", k); end
    n_cmp++; if (bus.result !== 8'h05 || bus.carry_out !== 1'b1) begin
      n_bad++; $display("FAIL b2b second_result: got %h co %b, expected 05 co 1", bus.result, bus.carry_out);
    end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0 || bus.result !== 8'h05) begin
      n_bad++; $display("FAIL b2b hold: done %b result %h, expected 0 05", bus.done, bus.result);
    end
  endtask
  initial begin
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_ctl = '0;
    test_reset();
    test_arith();
    test_logic();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
